// File: rtl/io_melody_player.sv
// Note sequencer: queues {dur_ms, halflen} entries and plays them back to the
// buzzer in order, with a silent gap after each note and pause/stop control.
module io_melody_player #(
    parameter int DEPTH      = 16,
    parameter int CLK_PER_MS = 50000,
    parameter int GAP_MS     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [31:0]            wr_data,
    input  logic                   enable,
    input  logic                   stop,
    output logic [31:0]            halflen,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   busy,
    output logic                   overflow,
    output logic                   done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_MS - 1);
    localparam logic [11:0]   GAP_LEN   = 12'(GAP_MS);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t         state, state_d;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [PW-1:0]  presc, presc_d;
    logic [11:0]    remain, remain_d;
    logic [19:0]    note, note_d;
    logic [19:0]    hl_q, hl_d;
    logic           done_d;
    logic           push, pop, tick;
    logic [31:0]    head;
    logic [11:0]    head_dur;
    logic [19:0]    head_note;

    assign full      = (count == CW'(DEPTH));
    assign busy      = (state != IDLE);
    assign halflen   = {12'b0, hl_q};
    // full is the registered pre-edge value, so a same-cycle pop cannot rescue a push
    assign push      = wr_en && !full;
    assign head      = mem[rd_ptr];
    assign head_dur  = head[31:20];
    assign head_note = head[19:0];
    assign tick      = enable && (presc == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        presc_d  = presc;
        remain_d = remain;
        note_d   = note;
        hl_d     = hl_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                hl_d    = '0;
                presc_d = '0;
                if (enable && count != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pop     = 1'b1;
                presc_d = '0;
                if (head_dur == '0) begin
                    hl_d    = '0;
                    state_d = IDLE;
                end else begin
                    remain_d = head_dur;
                    note_d   = head_note;
                    hl_d     = enable ? head_note : '0;
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                // paused: prescaler and remain hold, buzzer silenced
                hl_d = enable ? note : '0;
                if (enable) begin
                    presc_d = tick ? '0 : presc + PW'(1);
                end
                if (tick) begin
                    if (remain <= 12'd1) begin
                        hl_d = '0;
                        if (GAP_MS > 0) begin
                            remain_d = GAP_LEN;
                            state_d  = GAP;
                        end else if (count != '0) begin
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        remain_d = remain - 12'd1;
                    end
                end
            end
            GAP: begin
                hl_d = '0;
                if (enable) begin
                    presc_d = tick ? '0 : presc + PW'(1);
                end
                if (tick) begin
                    if (remain <= 12'd1) begin
                        if (count != '0) begin
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        remain_d = remain - 12'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || stop) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            hl_q     <= '0;
            presc    <= '0;
            remain   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            done   <= done_d;
            hl_q   <= hl_d;
            presc  <= presc_d;
            remain <= remain_d;
        end
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        note <= note_d;
        if (push && !stop && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule
